// File: rtl/pa_core_xirq_ctrl.sv
// External interrupt controller: synchronizes sources, latches edge/level pending state,
// picks the lowest-index enabled source and runs a claim/complete handshake with software.
module pa_core_xirq_ctrl #(
    parameter int unsigned IRQ_NUM = 8,
    parameter int unsigned ID_W    = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_src_i,
    input  logic               reg_re_i,
    input  logic               reg_we_i,
    input  logic [3:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o
);

    typedef enum logic [1:0] {SIdle, SReq, SServ, SGap} state_e;

    state_e             state_q, state_d;
    logic [IRQ_NUM-1:0] sync1_q, sync2_q, dly_q;
    logic [IRQ_NUM-1:0] enable_q, enable_d, trig_q, trig_d;
    logic [IRQ_NUM-1:0] pend_q, pend_d, insvc_q, insvc_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d, irq_id_q, irq_id_d;
    logic               irq_q, irq_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [IRQ_NUM-1:0] rise, pending, cand, cur_oh;
    logic [ID_W-1:0]    win_id;
    logic               found;
    logic               a_en, a_pend, a_claim, a_trig;
    logic               claim_rd, cpl_wr;

    always_comb begin
        rise    = sync2_q & ~dly_q;
        // Edge-mode bits come from the latch, level-mode bits follow the synchronized input.
        pending = (trig_q & pend_q) | (~trig_q & sync2_q);
        cand    = pending & enable_q & ~insvc_q;

        win_id = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < IRQ_NUM; i++) begin
            if (cand[i] && !found) begin
                win_id = ID_W'(i + 1);
                found  = 1'b1;
            end
        end

        for (int unsigned i = 0; i < IRQ_NUM; i++) begin
            cur_oh[i] = (cur_id_q == ID_W'(i + 1));
        end

        a_en    = (reg_addr_i == 4'h0);
        a_pend  = (reg_addr_i == 4'h4);
        a_claim = (reg_addr_i == 4'h8);
        a_trig  = (reg_addr_i == 4'hC);

        claim_rd = reg_re_i && a_claim && (state_q == SReq);
        cpl_wr   = reg_we_i && a_claim && (state_q == SServ)
                   && (reg_wdata_i[ID_W-1:0] == cur_id_q);

        enable_d = (reg_we_i && a_en)   ? reg_wdata_i[IRQ_NUM-1:0] : enable_q;
        trig_d   = (reg_we_i && a_trig) ? reg_wdata_i[IRQ_NUM-1:0] : trig_q;

        pend_d = pend_q;
        if (reg_we_i && a_pend) begin
            pend_d = pend_d & ~reg_wdata_i[IRQ_NUM-1:0];
        end
        pend_d = pend_d & ~(trig_q ^ trig_d);
        if (claim_rd) begin
            pend_d = pend_d & ~cur_oh;
        end
        // Applied last so a coincident rising edge beats any clear.
        pend_d = pend_d | (rise & trig_q);

        insvc_d = insvc_q;
        if (claim_rd) begin
            insvc_d = insvc_d | cur_oh;
        end
        if (cpl_wr) begin
            insvc_d = insvc_d & ~cur_oh;
        end

        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            SIdle: begin
                if (found) begin
                    cur_id_d = win_id;
                    state_d  = SReq;
                end
            end
            SReq: begin
                if (claim_rd) begin
                    state_d = SServ;
                end else if ((enable_d & cur_oh) == '0) begin
                    state_d = SGap;
                end
            end
            SServ: begin
                if (cpl_wr) begin
                    state_d = SGap;
                end
            end
            SGap:    state_d = SIdle;
            default: state_d = SIdle;
        endcase

        irq_d    = (state_d == SReq);
        irq_id_d = ((state_d == SReq) || (state_d == SServ)) ? cur_id_d : '0;

        rdata_d = '0;
        if (reg_re_i) begin
            if (a_en) begin
                rdata_d = 32'(enable_q);
            end else if (a_pend) begin
                rdata_d = 32'(pending);
            end else if (a_trig) begin
                rdata_d = 32'(trig_q);
            end else if (claim_rd) begin
                rdata_d = 32'(cur_id_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= SIdle;
            sync1_q  <= '0;
            sync2_q  <= '0;
            dly_q    <= '0;
            enable_q <= '0;
            trig_q   <= '0;
            pend_q   <= '0;
            insvc_q  <= '0;
            cur_id_q <= '0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= irq_src_i;
            sync2_q  <= sync1_q;
            dly_q    <= sync2_q;
            enable_q <= enable_d;
            trig_q   <= trig_d;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
            cur_id_q <= cur_id_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
            rdata_q  <= rdata_d;
        end
    end

    assign reg_rdata_o = rdata_q;
    assign irq_o       = irq_q;
    assign irq_id_o    = irq_id_q;

endmodule

// File: tb/tb_pa_core_xirq_ctrl.sv
// Self-checking bench for pa_core_xirq_ctrl: register vector table plus directed
// claim/complete sequences.
module tb_pa_core_xirq_ctrl;

    localparam logic [3:0] AEN = 4'h0, APEND = 4'h4, ACLAIM = 4'h8, ATRIG = 4'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  src;
    logic        re, we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [4:0]  irq_id;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    pa_core_xirq_ctrl #(.IRQ_NUM(8), .ID_W(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_src_i   (src),
        .reg_re_i    (re),
        .reg_we_i    (we),
        .reg_addr_i  (addr),
        .reg_wdata_i (wdata),
        .reg_rdata_o (rdata),
        .irq_o       (irq),
        .irq_id_o    (irq_id)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; wdata = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
    endtask

    task automatic pulse(input logic [7:0] m);
        src = m;
        @(negedge clk);
        src = '0;
    endtask

    task automatic wait_irq(input string nm);
        int n = 0;
        while (!irq && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'b0, irq}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        vecs[0]  = '{1'b0, 1'b1, AEN,   32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b0, AEN,   32'h0000_01A5, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, AEN,   32'h0,        32'hA5};
        vecs[3]  = '{1'b1, 1'b0, ATRIG, 32'hFFFF_FF3C, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, ATRIG, 32'h0,        32'h3C};
        vecs[5]  = '{1'b0, 1'b1, APEND, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 1'b1, ACLAIM, 32'h0,       32'h0};
        vecs[7]  = '{1'b0, 1'b1, 4'h3,  32'h0,        32'h0};
        vecs[8]  = '{1'b1, 1'b1, AEN,   32'h0F,       32'hA5};
        vecs[9]  = '{1'b1, 1'b0, 4'h1,  32'hFF,       32'h0};
        vecs[10] = '{1'b0, 1'b1, AEN,   32'h0,        32'h0F};
        vecs[11] = '{1'b1, 1'b0, ATRIG, 32'h0,        32'h0};

        rst = 1'b1; src = '0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        idle(3);
        chk("reset_irq", {31'b0, irq}, 32'd0);
        chk("reset_id", {27'b0, irq_id}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr; wdata = vecs[i].wdata;
            @(negedge clk);
            we = 1'b0; re = 1'b0; wdata = '0;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'd0);
        end
        wr(AEN, 32'h0);

        // Single edge source: latency and claim.
        wr(AEN, 32'h01);
        wr(ATRIG, 32'h01);
        pulse(8'h01);
        @(negedge clk);
        chk("t1_lat2", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("t1_lat3", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("t1_lat4", {31'b0, irq}, 32'd1);
        chk("t1_id", {27'b0, irq_id}, 32'd1);
        rd(ACLAIM, d);
        chk("t1_claim", d, 32'd1);
        chk("t1_irq_fall", {31'b0, irq}, 32'd0);
        chk("t1_id_serv", {27'b0, irq_id}, 32'd1);
        rd(APEND, d);
        chk("t1_pend", d, 32'd0);
        wr(ACLAIM, 32'd1);
        idle(3);

        // Two edge sources at once: priority, then gap timing.
        wr(AEN, 32'hFF);
        wr(ATRIG, 32'hFF);
        pulse(8'h24);
        wait_irq("t2_req");
        rd(ACLAIM, d);
        chk("t2_claim3", d, 32'd3);
        rd(APEND, d);
        chk("t2_pend", d, 32'h20);
        wr(ACLAIM, 32'd3);
        chk("t2_gap1", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("t2_gap2", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("t2_rereq", {31'b0, irq}, 32'd1);
        chk("t2_id6", {27'b0, irq_id}, 32'd6);
        rd(ACLAIM, d);
        chk("t2_claim6", d, 32'd6);
        wr(ACLAIM, 32'd6);
        idle(3);

        // Level source.
        wr(ATRIG, 32'h00);
        wr(AEN, 32'h02);
        src = 8'h02;
        wait_irq("t3_req");
        rd(ACLAIM, d);
        chk("t3_claim", d, 32'd2);
        idle(4);
        chk("t3_no_rereq", {31'b0, irq}, 32'd0);
        chk("t3_id_serv", {27'b0, irq_id}, 32'd2);
        wr(ACLAIM, 32'd2);
        chk("t3_gap1", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("t3_gap2", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("t3_rereq", {31'b0, irq}, 32'd1);
        rd(ACLAIM, d);
        chk("t3_claim2", d, 32'd2);
        src = 8'h00;
        idle(4);
        wr(ACLAIM, 32'd2);
        idle(6);
        chk("t3_quiet_irq", {31'b0, irq}, 32'd0);
        chk("t3_quiet_id", {27'b0, irq_id}, 32'd0);
        rd(APEND, d);
        chk("t3_pend", d, 32'd0);

        // Mismatched complete is ignored.
        wr(AEN, 32'h01);
        wr(ATRIG, 32'h01);
        pulse(8'h01);
        wait_irq("t4_req");
        rd(ACLAIM, d);
        chk("t4_claim", d, 32'd1);
        wr(ACLAIM, 32'd4);
        idle(3);
        chk("t4_stay_id", {27'b0, irq_id}, 32'd1);
        chk("t4_stay_irq", {31'b0, irq}, 32'd0);
        rd(ACLAIM, d);
        chk("t4_claim_serv", d, 32'd0);
        wr(ACLAIM, 32'd1);
        chk("t4_gap_id", {27'b0, irq_id}, 32'd0);
        idle(3);

        // Disable while requesting.
        pulse(8'h01);
        wait_irq("t5_req");
        wr(AEN, 32'h00);
        chk("t5_drop", {31'b0, irq}, 32'd0);
        rd(APEND, d);
        chk("t5_pend", d, 32'h01);
        wr(AEN, 32'h01);
        wait_irq("t5_reissue");
        chk("t5_id", {27'b0, irq_id}, 32'd1);
        rd(ACLAIM, d);
        chk("t5_claim", d, 32'd1);
        wr(ACLAIM, 32'd1);
        idle(3);

        // Reset during service.
        pulse(8'h01);
        wait_irq("t6_req");
        rd(ACLAIM, d);
        chk("t6_claim", d, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_irq", {31'b0, irq}, 32'd0);
        chk("t6_rst_id", {27'b0, irq_id}, 32'd0);
        chk("t6_rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        rd(APEND, d);
        chk("t6_pend", d, 32'd0);
        rd(AEN, d);
        chk("t6_en", d, 32'd0);
        wr(AEN, 32'h01);
        wr(ATRIG, 32'h01);
        pulse(8'h01);
        wait_irq("t6_req2");
        chk("t6_id", {27'b0, irq_id}, 32'd1);
        rd(ACLAIM, d);
        chk("t6_claim2", d, 32'd1);
        wr(ACLAIM, 32'd1);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
